// File: rtl/elm_neuron_mac.sv
// ELM hidden-layer neuron: streams inputs against a 1-cycle-latency weight memory,
// accumulates at full precision, adds bias, optional ReLU, saturates to dataWidth.
module elm_neuron_mac #(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracBits     = 8,
  parameter int actType      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [dataWidth-1:0] in_data,
  output logic                        ren,
  output logic [addressWidth:0]       raddr,
  input  logic signed [dataWidth-1:0] wout,
  input  logic signed [dataWidth-1:0] bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [dataWidth-1:0] out_data
);

  localparam int PROD_W = 2 * dataWidth;
  localparam int ACC_W  = PROD_W + addressWidth + 1;
  localparam int SUM_W  = ACC_W + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACC   = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] FINAL = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);

  logic [2:0]               state;
  logic                     run_q;
  logic                     accept;
  logic [addressWidth-1:0]  cnt;
  logic signed [dataWidth-1:0] x_p1;
  logic                     vld_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]  acc_p2;

  // Bias aligned to the product's binary point, then back to dataWidth scaling (floor).
  function automatic logic signed [SUM_W-1:0] scale_fn(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [dataWidth-1:0] b);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + (SUM_W'(b) <<< fracBits);
    return s >>> fracBits;
  endfunction

  function automatic logic signed [SUM_W-1:0] relu_fn(input logic signed [SUM_W-1:0] r);
    if (actType == 1 && r[SUM_W-1]) return '0;
    return r;
  endfunction

  function automatic logic signed [dataWidth-1:0] sat_fn(input logic signed [SUM_W-1:0] v);
    logic [SUM_W-dataWidth:0] hi;
    hi = v[SUM_W-1:dataWidth-1];
    if ((&hi) || !(|hi)) return v[dataWidth-1:0];
    if (v[SUM_W-1]) return {1'b1, {(dataWidth-1){1'b0}}};
    return {1'b0, {(dataWidth-1){1'b1}}};
  endfunction

  // run_q keeps in_ready low until the first edge after reset release.
  assign in_ready = run_q && (state == IDLE || state == ACC);
  assign accept   = in_valid && in_ready;
  assign ren      = accept;
  assign raddr    = accept ? {1'b0, cnt} : '0;
  assign prod_p1  = PROD_W'(x_p1) * PROD_W'(wout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_q     <= 1'b0;
      cnt       <= '0;
      x_p1      <= '0;
      vld_p1    <= 1'b0;
      acc_p2    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      run_q  <= 1'b1;
      // p0 -> p1: register the accepted sample alongside its memory read
      vld_p1 <= accept;
      if (accept) begin
        x_p1 <= in_data;
        cnt  <= cnt + addressWidth'(1);
      end
      // p1 -> p2: weight arrives now, accumulate only for a real read
      if (vld_p1) acc_p2 <= acc_p2 + ACC_W'(prod_p1);

      case (state)
        IDLE, ACC: if (accept) state <= (cnt == LAST) ? DRAIN : ACC;
        DRAIN:     state <= FINAL;
        FINAL: begin
          out_data  <= sat_fn(relu_fn(scale_fn(acc_p2, bias)));
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_p2    <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elm_neuron_mac.sv
// Directed bench for elm_neuron_mac: linear and ReLU instances share stimulus and a
// 1-cycle-latency weight memory model; expected results are hand-computed constants.
module tb_elm_neuron_mac;
  localparam int NW = 4;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int FB = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic [DW-1:0] bias;
  logic [DW-1:0] wout;
  logic          in_ready, ren, out_valid;
  logic [AW:0]   raddr;
  logic [DW-1:0] out_data;
  logic          in_ready_r, ren_r, out_valid_r;
  logic [AW:0]   raddr_r;
  logic [DW-1:0] out_data_r;

  logic [DW-1:0] wmem [NW];

  int n_checks = 0;
  int n_fail   = 0;

  elm_neuron_mac #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(FB), .actType(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ren(ren), .raddr(raddr), .wout(wout), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  elm_neuron_mac #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(FB), .actType(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .ren(ren_r), .raddr(raddr_r), .wout(wout), .bias(bias),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ren) wout <= wmem[raddr[1:0]];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic set_neuron(input logic [DW-1:0] w, input logic [DW-1:0] b);
    for (int i = 0; i < NW; i++) wmem[i] = w;
    bias = b;
  endtask

  // Starts and ends on a negedge with the block ready to accept.
  task automatic feed4(input logic [DW-1:0] x);
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1;
      in_data  = x;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic ok, output logic [DW-1:0] d, output logic [DW-1:0] dr);
    ok = 1'b0; d = '0; dr = '0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1; d = out_data; dr = out_data_r;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h0100; out_ready = 1'b1;
    set_neuron(16'h0080, 16'h0100);
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_checks++; if (ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %b exp 0", ren); end
    n_checks++; if (raddr !== '0) begin n_fail++; $display("FAIL reset_raddr got %0d exp 0", raddr); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_in_ready got %b exp 0", in_ready); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_edge_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic;
    set_neuron(16'h0080, 16'h0100);
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1; in_data = 16'h0100;
      #1;
      n_checks++;
      if ({ren, raddr} !== {1'b1, 4'(i)}) begin n_fail++; $display("FAIL basic_raddr got ren=%b raddr=%0d exp ren=1 raddr=%0d", ren, raddr, i); end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL basic_drain got out_valid=%b in_ready=%b exp 0 0", out_valid, in_ready); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_final_out_valid got %b exp 0", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_out_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== 16'h0300) begin n_fail++; $display("FAIL basic_out got %h exp 0300", out_data); end
    n_checks++; if (out_data_r !== 16'h0300) begin n_fail++; $display("FAIL basic_out_relu got %h exp 0300", out_data_r); end
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_handshake got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_gapped;
    logic [6:0] pat;
    logic ok;
    logic [DW-1:0] d, dr;
    int k;
    pat = 7'b1001011;
    k = 0;
    set_neuron(16'h0080, 16'h0100);
    for (int j = 0; j < 7; j++) begin
      in_valid = pat[6-j]; in_data = 16'h0100;
      #1;
      n_checks++;
      if (pat[6-j]) begin
        if ({ren, raddr} !== {1'b1, 4'(k)}) begin n_fail++; $display("FAIL gapped_raddr got ren=%b raddr=%0d exp ren=1 raddr=%0d", ren, raddr, k); end
        k++;
      end else begin
        if (ren !== 1'b0) begin n_fail++; $display("FAIL gapped_ren_idle got %b exp 0", ren); end
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out(ok, d, dr);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL gapped_timeout got no out_valid exp out_valid"); end
    n_checks++; if (d !== 16'h0300) begin n_fail++; $display("FAIL gapped_out got %h exp 0300", d); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL gapped_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_saturation;
    logic ok;
    logic [DW-1:0] d, dr;
    set_neuron(16'h7FFF, 16'h0000);
    feed4(16'h7FFF);
    wait_out(ok, d, dr);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_pos_timeout got no out_valid exp out_valid"); end
    n_checks++; if (d !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos got %h exp 7fff", d); end
    n_checks++; if (dr !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos_relu got %h exp 7fff", dr); end
    @(negedge clk);
    feed4(16'h8000);
    wait_out(ok, d, dr);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_neg_timeout got no out_valid exp out_valid"); end
    n_checks++; if (d !== 16'h8000) begin n_fail++; $display("FAIL sat_neg got %h exp 8000", d); end
    n_checks++; if (dr !== 16'h0000) begin n_fail++; $display("FAIL sat_neg_relu got %h exp 0000", dr); end
    @(negedge clk);
  endtask

  task automatic test_relu;
    logic ok;
    logic [DW-1:0] d, dr;
    set_neuron(16'hFF00, 16'h0000);
    feed4(16'h0100);
    wait_out(ok, d, dr);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL relu_timeout got no out_valid exp out_valid"); end
    n_checks++; if (d !== 16'hFC00) begin n_fail++; $display("FAIL relu_linear got %h exp fc00", d); end
    n_checks++; if (dr !== 16'h0000) begin n_fail++; $display("FAIL relu_clamped got %h exp 0000", dr); end
    @(negedge clk);
    // -4 LSB of product scale floors to -1, not 0
    set_neuron(16'hFFFF, 16'h0000);
    feed4(16'h0001);
    wait_out(ok, d, dr);
    n_checks++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL trunc_floor got %h exp ffff", d); end
    n_checks++; if (dr !== 16'h0000) begin n_fail++; $display("FAIL trunc_floor_relu got %h exp 0000", dr); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic ok;
    logic [DW-1:0] d, dr;
    out_ready = 1'b0;
    set_neuron(16'h0080, 16'h0100);
    feed4(16'h0100);
    wait_out(ok, d, dr);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got no out_valid exp out_valid"); end
    n_checks++; if (d !== 16'h0300) begin n_fail++; $display("FAIL bp_first_out got %h exp 0300", d); end
    in_valid = 1'b1; in_data = 16'h0200;
    for (int s = 0; s < 5; s++) begin
      #1;
      n_checks++;
      if ({out_valid, out_data, in_ready, ren} !== {1'b1, 16'h0300, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold got out_valid=%b out_data=%h in_ready=%b ren=%b exp 1 0300 0 0", out_valid, out_data, in_ready, ren);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b exp 0", out_valid); end
    for (int i = 0; i < NW; i++) begin
      #1;
      n_checks++;
      if ({ren, raddr} !== {1'b1, 4'(i)}) begin n_fail++; $display("FAIL bp_second_raddr got ren=%b raddr=%0d exp ren=1 raddr=%0d", ren, raddr, i); end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out(ok, d, dr);
    n_checks++; if (d !== 16'h0500) begin n_fail++; $display("FAIL bp_second_out got %h exp 0500", d); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic ok;
    logic [DW-1:0] d, dr;
    set_neuron(16'h0080, 16'h0100);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'h0100;
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL midrst_out_data got %h exp 0000", out_data); end
    n_checks++;
    if ({out_valid, in_ready, ren, raddr} !== '0) begin
      n_fail++;
      $display("FAIL midrst_ctrl got out_valid=%b in_ready=%b ren=%b raddr=%0d exp all 0", out_valid, in_ready, ren, raddr);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    feed4(16'h0100);
    wait_out(ok, d, dr);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_timeout got no out_valid exp out_valid"); end
    n_checks++; if (d !== 16'h0300) begin n_fail++; $display("FAIL midrst_fresh_out got %h exp 0300", d); end
    @(negedge clk);
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; bias = '0; rst_n = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_saturation();
    test_relu();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
